// File: rtl/frame_src_sched.sv
// Frame-source scheduler: arbitrates a shared stream source among NREQ
// requesters. Each winner gets a burst of whole frames, where a frame starts
// at the falling edge of vsync (SOF). Lines are counted on dvalid rising edges.
module frame_src_sched #(
   parameter int NREQ = 4,
   parameter int NFW  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  vsync,
   input  logic                  dvalid,
   input  logic [NREQ-1:0]       req,
   input  logic [4*NREQ-1:0]     req_src,
   input  logic [NFW*NREQ-1:0]   req_nframes,
   output logic [NREQ-1:0]       grant,
   output logic [3:0]            src_sel,
   output logic                  busy,
   output logic                  frame_start,
   output logic [NREQ-1:0]       frame_done,
   output logic [NFW-1:0]        frame_cnt,
   output logic [10:0]           line_cnt
);

   localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {
      IDLE,
      ARB,
      WAIT_SOF,
      STREAM,
      DONE
   } state_t;

   state_t          state;
   logic            vsync_q;
   logic            dvalid_q;
   logic            sof;
   logic            dvalid_rise;
   logic [OW-1:0]   rr_ptr;
   logic [OW-1:0]   owner;
   logic [OW-1:0]   winner;
   logic [OW-1:0]   cand;
   logic [NFW-1:0]  nlat;
   logic            owner_req;
   logic [3:0]      src_arr [NREQ];
   logic [NFW-1:0]  nf_arr  [NREQ];

   assign sof         = vsync_q & ~vsync;
   assign dvalid_rise = dvalid & ~dvalid_q;
   assign busy        = (state != IDLE);
   assign owner_req   = req[owner];

   // Split the packed per-requester fields into indexable arrays.
   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign src_arr[i] = req_src[4*i +: 4];
      assign nf_arr[i]  = req_nframes[NFW*i +: NFW];
   end

   // Wrap-around increment used for the round-robin pointer.
   function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] v);
      if (int'(v) == NREQ - 1) begin
         return '0;
      end else begin
         return v + OW'(1);
      end
   endfunction

   // Round-robin search: scan downward so the set bit closest to rr_ptr wins.
   always_comb begin
      winner = rr_ptr;
      cand   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = OW'((int'(rr_ptr) + k) % NREQ);
         if (req[cand]) begin
            winner = cand;
         end
      end
   end

   // Sync/valid history and the saturating line counter, active in every state.
   always_ff @(posedge clk) begin
      if (reset) begin
         vsync_q  <= 1'b1;
         dvalid_q <= 1'b0;
         line_cnt <= '0;
      end else begin
         vsync_q  <= vsync;
         dvalid_q <= dvalid;
         if (sof) begin
            line_cnt <= dvalid_rise ? 11'd1 : 11'd0;
         end else if (dvalid_rise && (line_cnt != 11'd2047)) begin
            line_cnt <= line_cnt + 11'd1;
         end
      end
   end

   // Burst scheduler FSM with registered grant, select and pulse outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         grant       <= '0;
         src_sel     <= '0;
         frame_start <= 1'b0;
         frame_done  <= '0;
         frame_cnt   <= '0;
         rr_ptr      <= '0;
         owner       <= '0;
         nlat        <= '0;
      end else begin
         frame_start <= 1'b0;
         frame_done  <= '0;
         case (state)
            IDLE: begin
               if (|req) begin
                  state <= ARB;
               end
            end
            ARB: begin
               frame_cnt <= '0;
               if (|req) begin
                  grant   <= NREQ'(1) << winner;
                  owner   <= winner;
                  src_sel <= src_arr[winner];
                  nlat    <= (nf_arr[winner] == '0) ? NFW'(1) : nf_arr[winner];
                  state   <= WAIT_SOF;
               end else begin
                  state <= IDLE;
               end
            end
            WAIT_SOF: begin
               if (!owner_req) begin
                  grant <= '0;
                  state <= IDLE;
               end else if (sof) begin
                  frame_start <= 1'b1;
                  frame_cnt   <= NFW'(1);
                  state       <= STREAM;
               end
            end
            STREAM: begin
               if (sof) begin
                  if ((frame_cnt == nlat) || !owner_req) begin
                     frame_done <= NREQ'(1) << owner;
                     state      <= DONE;
                  end else begin
                     frame_start <= 1'b1;
                     frame_cnt   <= frame_cnt + NFW'(1);
                  end
               end
            end
            DONE: begin
               grant  <= '0;
               rr_ptr <= next_idx(owner);
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_src_sched.sv
// Self-checking bench for frame_src_sched: a table of directed bursts, hand
// sequences for the multi-cycle corner cases, and randomized bursts checked
// against a transaction-level model of the arbitration and burst rules.
module tb_frame_src_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        vsync;
   logic        dvalid;
   logic [3:0]  req;
   logic [15:0] req_src;
   logic [31:0] req_nframes;
   logic [3:0]  grant;
   logic [3:0]  src_sel;
   logic        busy;
   logic        frame_start;
   logic [3:0]  frame_done;
   logic [7:0]  frame_cnt;
   logic [10:0] line_cnt;

   int checks = 0;
   int failures = 0;
   int fs_total = 0;
   int fd_total[4] = '{0, 0, 0, 0};
   int onehot_viol = 0;
   int model_lines = 0;

   typedef struct {
      bit          do_reset;
      bit          hold;
      logic [3:0]  req;
      logic [15:0] src;
      logic [31:0] nf;
      logic [3:0]  exp_grant;
      logic [3:0]  exp_src;
      int          exp_frames;
   } vec_t;

   vec_t vecs[9];

   frame_src_sched #(.NREQ(4), .NFW(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .vsync       (vsync),
      .dvalid      (dvalid),
      .req         (req),
      .req_src     (req_src),
      .req_nframes (req_nframes),
      .grant       (grant),
      .src_sel     (src_sel),
      .busy        (busy),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .frame_cnt   (frame_cnt),
      .line_cnt    (line_cnt)
   );

   // Free-running pixel clock.
   always #5 clk = ~clk;

   // Pulse counters and one-hot watch, sampled on the inactive edge.
   always @(negedge clk) begin
      if (frame_start === 1'b1) fs_total++;
      for (int i = 0; i < 4; i++) begin
         if (frame_done[i] === 1'b1) fd_total[i]++;
      end
      if ($countones(grant) > 1) onehot_viol++;
   end

   // Hard stop in case something wedges the sequence.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      req    = '0;
      vsync  = 1'b1;
      dvalid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      model_lines = 0;
   endtask

   task automatic dv_pulses(input int n);
      for (int i = 0; i < n; i++) begin
         dvalid = 1'b1;
         tick();
         dvalid = 1'b0;
         tick();
         if (model_lines < 2047) model_lines++;
      end
   endtask

   // One SOF: vsync low for a cycle, then high again so the next SOF can follow.
   task automatic sof_pulse(output bit got_done, output bit got_start, output logic [7:0] fc);
      vsync = 1'b0;
      tick();
      got_done  = |frame_done;
      got_start = frame_start;
      fc        = frame_cnt;
      model_lines = 0;
      vsync = 1'b1;
      tick();
   endtask

   task automatic wait_grant();
      int c;
      c = 0;
      while (grant == '0 && c < 16) begin
         tick();
         c++;
      end
   endtask

   task automatic fd_delta(input int base[4], output logic [3:0] bits, output int total);
      total = 0;
      for (int i = 0; i < 4; i++) begin
         bits[i] = ((fd_total[i] - base[i]) != 0);
         total += fd_total[i] - base[i];
      end
   endtask

   task automatic run_sofs(input int max_sofs, input int drop_after, input bit with_lines,
                           output int starts, output bit done, output logic [7:0] fc);
      bit gd, gs;
      logic [7:0] fcx;
      int n;
      starts = 0;
      done   = 1'b0;
      fc     = '0;
      for (int s = 0; s < max_sofs && !done; s++) begin
         if (with_lines) begin
            n = $urandom_range(0, 5);
            dv_pulses(n);
            check_output("line_cnt_before_sof", 32'(line_cnt), 32'(model_lines));
         end
         sof_pulse(gd, gs, fcx);
         if (gs) starts++;
         if (gd) begin
            done = 1'b1;
            fc   = fcx;
         end else if (drop_after != 0 && starts == drop_after) begin
            req = '0;
         end
         if (with_lines) check_output("line_cnt_after_sof", 32'(line_cnt), 32'(model_lines));
      end
   endtask

   // Directed burst table applied in order.
   task automatic apply_stimulus();
      int fs0, starts, total;
      int fd0[4];
      bit done;
      logic [7:0] fc;
      logic [3:0] bits;
      for (int k = 0; k < 9; k++) begin
         if (vecs[k].do_reset) do_reset();
         fs0 = fs_total;
         fd0 = fd_total;
         req         = vecs[k].req;
         req_src     = vecs[k].src;
         req_nframes = vecs[k].nf;
         wait_grant();
         check_output($sformatf("vec%0d_grant", k), 32'(grant), 32'(vecs[k].exp_grant));
         check_output($sformatf("vec%0d_src_sel", k), 32'(src_sel), 32'(vecs[k].exp_src));
         run_sofs(12, 0, 1'b0, starts, done, fc);
         check_output($sformatf("vec%0d_done", k), 32'(done), 32'd1);
         check_output($sformatf("vec%0d_starts", k), 32'(starts), 32'(vecs[k].exp_frames));
         check_output($sformatf("vec%0d_frame_cnt", k), 32'(fc), 32'(vecs[k].exp_frames));
         check_output($sformatf("vec%0d_busy_after", k), 32'(busy), 32'd0);
         check_output($sformatf("vec%0d_fs_pulses", k), 32'(fs_total - fs0), 32'(vecs[k].exp_frames));
         fd_delta(fd0, bits, total);
         check_output($sformatf("vec%0d_done_bit", k), 32'(bits), 32'(vecs[k].exp_grant));
         check_output($sformatf("vec%0d_done_count", k), 32'(total), 32'd1);
         check_output($sformatf("vec%0d_src_hold", k), 32'(src_sel), 32'(vecs[k].exp_src));
         if (!vecs[k].hold) req = '0;
      end
   endtask

   initial begin
      int fs0, starts, total, ptr, w, nexp, dropk, expf;
      int fd0[4];
      bit gd, gs, done;
      logic [7:0] fc;
      logic [3:0] bits, r, exp_src;
      logic [15:0] srcs;
      logic [31:0] nfs;
      logic [7:0] nfv;

      vecs[0] = '{1'b1, 1'b0, 4'b0001, 16'h0003, 32'h00000002, 4'b0001, 4'h3, 2};
      vecs[1] = '{1'b1, 1'b1, 4'b1111, 16'hDCBA, 32'h01010101, 4'b0001, 4'hA, 1};
      vecs[2] = '{1'b0, 1'b1, 4'b1111, 16'hDCBA, 32'h01010101, 4'b0010, 4'hB, 1};
      vecs[3] = '{1'b0, 1'b1, 4'b1111, 16'hDCBA, 32'h01010101, 4'b0100, 4'hC, 1};
      vecs[4] = '{1'b0, 1'b1, 4'b1111, 16'hDCBA, 32'h01010101, 4'b1000, 4'hD, 1};
      vecs[5] = '{1'b0, 1'b0, 4'b1111, 16'hDCBA, 32'h01010101, 4'b0001, 4'hA, 1};
      vecs[6] = '{1'b0, 1'b0, 4'b0100, 16'h0500, 32'h00000000, 4'b0100, 4'h5, 1};
      vecs[7] = '{1'b0, 1'b0, 4'b1010, 16'h9070, 32'h03000300, 4'b1000, 4'h9, 3};
      vecs[8] = '{1'b0, 1'b0, 4'b1010, 16'h9070, 32'h03000300, 4'b0010, 4'h7, 3};

      reset = 1'b1; vsync = 1'b1; dvalid = 1'b0;
      req = '0; req_src = '0; req_nframes = '0;
      tick();
      tick();
      check_output("rst_grant", 32'(grant), 32'd0);
      check_output("rst_src_sel", 32'(src_sel), 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_frame_start", 32'(frame_start), 32'd0);
      check_output("rst_frame_done", 32'(frame_done), 32'd0);
      check_output("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check_output("rst_line_cnt", 32'(line_cnt), 32'd0);
      reset = 1'b0;
      tick();

      apply_stimulus();

      // Early drop: owner releases mid-frame 2 of a 5-frame burst.
      do_reset();
      fs0 = fs_total; fd0 = fd_total;
      req = 4'b0001; req_src = 16'h0006; req_nframes = 32'h00000005;
      wait_grant();
      check_output("drop_grant", 32'(grant), 32'd1);
      sof_pulse(gd, gs, fc);
      sof_pulse(gd, gs, fc);
      check_output("drop_cnt_frame2", 32'(fc), 32'd2);
      dv_pulses(3);
      req = '0;
      tick(); tick(); tick();
      check_output("drop_busy_midframe", 32'(busy), 32'd1);
      check_output("drop_cnt_midframe", 32'(frame_cnt), 32'd2);
      sof_pulse(gd, gs, fc);
      check_output("drop_done", 32'(gd), 32'd1);
      check_output("drop_no_start", 32'(gs), 32'd0);
      check_output("drop_frame_cnt", 32'(fc), 32'd2);
      fd_delta(fd0, bits, total);
      check_output("drop_done_bit", 32'(bits), 32'd1);
      check_output("drop_fs_pulses", 32'(fs_total - fs0), 32'd2);

      // WAIT_SOF abort: no frame_done and the round-robin pointer stays put.
      fs0 = fs_total; fd0 = fd_total;
      req = 4'b0010; req_src = 16'h00E0; req_nframes = 32'h00000300;
      wait_grant();
      check_output("abort_grant", 32'(grant), 32'b0010);
      req = '0;
      tick();
      check_output("abort_grant_clear", 32'(grant), 32'd0);
      check_output("abort_busy", 32'(busy), 32'd0);
      tick(); tick();
      fd_delta(fd0, bits, total);
      check_output("abort_no_done", 32'(total), 32'd0);
      check_output("abort_no_start", 32'(fs_total - fs0), 32'd0);
      req = 4'b1111;
      wait_grant();
      check_output("abort_ptr_kept", 32'(grant), 32'b0010);
      req = '0;
      tick(); tick();

      // Reset in the middle of a stream.
      req = 4'b0100; req_src = 16'h0B00; req_nframes = 32'h00040000;
      wait_grant();
      check_output("rstmid_grant", 32'(grant), 32'b0100);
      sof_pulse(gd, gs, fc);
      sof_pulse(gd, gs, fc);
      dv_pulses(5);
      check_output("rstmid_lines_before", 32'(line_cnt), 32'd5);
      fd0 = fd_total;
      reset = 1'b1;
      tick();
      check_output("rstmid_grant_zero", 32'(grant), 32'd0);
      check_output("rstmid_src_zero", 32'(src_sel), 32'd0);
      check_output("rstmid_busy_zero", 32'(busy), 32'd0);
      check_output("rstmid_fs_zero", 32'(frame_start), 32'd0);
      check_output("rstmid_fd_zero", 32'(frame_done), 32'd0);
      check_output("rstmid_cnt_zero", 32'(frame_cnt), 32'd0);
      check_output("rstmid_lines_zero", 32'(line_cnt), 32'd0);
      reset = 1'b0; req = '0; model_lines = 0;
      tick(); tick();
      fd_delta(fd0, bits, total);
      check_output("rstmid_no_done", 32'(total), 32'd0);
      req = 4'b1111;
      wait_grant();
      check_output("rstmid_next_grant", 32'(grant), 32'b0001);
      req = '0;
      tick(); tick();

      // Line counting, coincident SOF/edge and saturation.
      do_reset();
      dv_pulses(512);
      check_output("lines_512", 32'(line_cnt), 32'd512);
      sof_pulse(gd, gs, fc);
      check_output("lines_clear_on_sof", 32'(line_cnt), 32'd0);
      dv_pulses(4);
      vsync = 1'b0; dvalid = 1'b1;
      tick();
      check_output("lines_sof_and_edge", 32'(line_cnt), 32'd1);
      vsync = 1'b1; dvalid = 1'b0;
      tick();
      model_lines = 1;
      dv_pulses(2100);
      check_output("lines_saturate", 32'(line_cnt), 32'(model_lines));
      sof_pulse(gd, gs, fc);
      check_output("lines_clear_after_sat", 32'(line_cnt), 32'd0);

      // Randomized bursts against the transaction-level model.
      do_reset();
      ptr = 0;
      for (int b = 0; b < 40; b++) begin
         r = 4'($urandom_range(1, 15));
         srcs = 16'($urandom);
         for (int i = 0; i < 4; i++) nfs[8*i +: 8] = 8'($urandom_range(0, 4));
         w = -1;
         for (int k = 0; k < 4; k++) begin
            if (w < 0 && r[(ptr + k) % 4]) w = (ptr + k) % 4;
         end
         exp_src = srcs[4*w +: 4];
         nfv     = nfs[8*w +: 8];
         nexp    = (nfv == 0) ? 1 : int'(nfv);
         dropk   = $urandom_range(0, 3);
         expf    = (dropk != 0 && dropk < nexp) ? dropk : nexp;
         fs0 = fs_total; fd0 = fd_total;
         req = r; req_src = srcs; req_nframes = nfs;
         wait_grant();
         check_output($sformatf("rnd%0d_grant", b), 32'(grant), 32'(4'b0001 << w));
         check_output($sformatf("rnd%0d_src_sel", b), 32'(src_sel), 32'(exp_src));
         req_src = 16'($urandom);
         req_nframes = $urandom;
         run_sofs(12, dropk, 1'b1, starts, done, fc);
         check_output($sformatf("rnd%0d_done", b), 32'(done), 32'd1);
         check_output($sformatf("rnd%0d_starts", b), 32'(starts), 32'(expf));
         check_output($sformatf("rnd%0d_frame_cnt", b), 32'(fc), 32'(expf));
         fd_delta(fd0, bits, total);
         check_output($sformatf("rnd%0d_done_bit", b), 32'(bits), 32'(4'b0001 << w));
         check_output($sformatf("rnd%0d_src_hold", b), 32'(src_sel), 32'(exp_src));
         ptr = (w + 1) % 4;
         req = '0;
         tick();
      end

      check_output("grant_onehot", 32'(onehot_viol), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
